calc_accumulator: RTL and testbench

- Push-button 16-bit accumulator calculator for the FPGA board top level.
- Keeps a 16-bit accumulator that is always shown on `led`.
- On each press of `btnd`, the accumulator is replaced by ALU(accumulator, `sw`).
- The ALU operation is chosen by the `btnl`/`btnc`/`btnr` buttons.

---
 rtl/calc_pkg.sv | 17 +
 rtl/alu.sv | 33 +++
 rtl/calc_accumulator.sv | 73 +++++++
 tb/tb_calc_accumulator.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the push-button accumulator calculator: data width and ALU op codes.
package calc_pkg;

    localparam int unsigned CALC_WIDTH = 16;

    typedef enum logic [3:0] {
        ALUOP_ADD = 4'd0,
        ALUOP_SUB = 4'd1,
        ALUOP_AND = 4'd2,
        ALUOP_OR  = 4'd3,
        ALUOP_XOR = 4'd4,
        ALUOP_LT  = 4'd5,
        ALUOP_SLL = 4'd6,
        ALUOP_SRA = 4'd7
    } alu_op_e;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU with a zero flag.
module alu
    import calc_pkg::*;
(
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  alu_op_e     i_alu_op,
    output logic [31:0] o_result,
    output logic        o_zero
);

    logic [4:0] w_shamt;

    assign w_shamt = i_op_b[4:0];

    always_comb begin
        o_result = '0;
        unique case (i_alu_op)
            ALUOP_ADD: o_result = i_op_a + i_op_b;
            ALUOP_SUB: o_result = i_op_a - i_op_b;
            ALUOP_AND: o_result = i_op_a & i_op_b;
            ALUOP_OR:  o_result = i_op_a | i_op_b;
            ALUOP_XOR: o_result = i_op_a ^ i_op_b;
            ALUOP_LT:  o_result = {31'd0, $signed(i_op_a) < $signed(i_op_b)};
            ALUOP_SLL: o_result = i_op_a << w_shamt;
            ALUOP_SRA: o_result = $unsigned($signed(i_op_a) >>> w_shamt);
            default:   o_result = '0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/calc_accumulator.sv
// Accumulator calculator: on each rising edge of btnd, acc <= ALU(acc, sw) with op from btnl/c/r.
module calc_accumulator
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             btnu,
    input  logic             btnc,
    input  logic             btnl,
    input  logic             btnr,
    input  logic             btnd,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] led
);

    logic [WIDTH-1:0] r_acc;
    logic             r_btnd_q;

    logic [2:0]  w_op_sel;
    alu_op_e     w_alu_op;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_result;
    logic        w_zero;
    logic        w_press;

    assign w_op_sel = {btnl, btnc, btnr};

    always_comb begin
        w_alu_op = ALUOP_ADD;
        unique case (w_op_sel)
            3'b000: w_alu_op = ALUOP_ADD;
            3'b001: w_alu_op = ALUOP_SUB;
            3'b010: w_alu_op = ALUOP_AND;
            3'b011: w_alu_op = ALUOP_OR;
            3'b100: w_alu_op = ALUOP_XOR;
            3'b101: w_alu_op = ALUOP_LT;
            3'b110: w_alu_op = ALUOP_SLL;
            3'b111: w_alu_op = ALUOP_SRA;
            default: w_alu_op = ALUOP_ADD;
        endcase
    end

    assign w_op_a = {{(32 - WIDTH){r_acc[WIDTH-1]}}, r_acc};
    assign w_op_b = {{(32 - WIDTH){sw[WIDTH-1]}}, sw};

    alu u_alu (
        .i_op_a   (w_op_a),
        .i_op_b   (w_op_b),
        .i_alu_op (w_alu_op),
        .o_result (w_result),
        .o_zero   (w_zero)
    );

    assign w_press = btnd && !r_btnd_q;

    // r_btnd_q clears on reset so a button held through reset release counts as a press.
    always_ff @(posedge clk) begin
        if (!btnu) begin
            r_acc    <= '0;
            r_btnd_q <= 1'b0;
        end else begin
            r_btnd_q <= btnd;
            if (w_press) begin
                r_acc <= w_result[WIDTH-1:0];
            end
        end
    end

    assign led = r_acc;

endmodule

// File: tb/tb_calc_accumulator.sv
// Self-checking bench for calc_accumulator: directed table, corner sequences, random vs model.
module tb_calc_accumulator;

    logic        clk;
    logic        btnu;
    logic        btnd;
    logic [2:0]  op_sel;
    logic [15:0] sw;
    logic [15:0] led;

    int unsigned n_pass;
    int unsigned n_total;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] sw;
        logic [15:0] exp;
    } vec_t;

    calc_accumulator dut (
        .clk  (clk),
        .btnu (btnu),
        .btnc (op_sel[1]),
        .btnl (op_sel[2]),
        .btnr (op_sel[0]),
        .btnd (btnd),
        .sw   (sw),
        .led  (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (got no finish, required finish)");
        $fatal(1, "watchdog");
    end

    // Reference ALU from arithmetic on sign-extended integers.
    function automatic logic [15:0] ref_alu(input logic [15:0] acc, input logic [2:0] op,
                                            input logic [15:0] b);
        longint a;
        longint bb;
        longint p;
        longint r;
        int     s;
        a  = $signed(acc);
        bb = $signed(b);
        s  = int'(b[4:0]);
        p  = 1;
        for (int i = 0; i < s; i++) p = p * 2;
        case (op)
            3'd0: r = a + bb;
            3'd1: r = a - bb;
            3'd2: r = a & bb;
            3'd3: r = a | bb;
            3'd4: r = a ^ bb;
            3'd5: r = (a < bb) ? 1 : 0;
            3'd6: r = a * p;
            default: r = (a >= 0) ? a / p : -((-a + p - 1) / p);
        endcase
        return r[15:0];
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: led=0x%04h expected 0x%04h", name, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clean press: high for one edge (checked), then low for one edge.
    task automatic press(input logic [2:0] op, input logic [15:0] b, input logic [15:0] want,
                         input string name);
        op_sel = op;
        sw     = b;
        btnd   = 1'b1;
        tick();
        check(name, led, want);
        btnd = 1'b0;
        tick();
    endtask

    vec_t chain [9];
    vec_t bnd   [4];
    logic [15:0] m_acc;
    logic        m_prev;

    initial begin
        n_pass  = 0;
        n_total = 0;
        btnu    = 1'b0;
        btnd    = 1'b0;
        op_sel  = 3'b000;
        sw      = 16'h0000;

        chain[0] = '{3'b011, 16'h1234, 16'h1234};
        chain[1] = '{3'b010, 16'h0FF0, 16'h0230};
        chain[2] = '{3'b000, 16'h324F, 16'h347F};
        chain[3] = '{3'b001, 16'h2D31, 16'h074E};
        chain[4] = '{3'b100, 16'hFFFF, 16'hF8B1};
        chain[5] = '{3'b101, 16'h7346, 16'h0001};
        chain[6] = '{3'b110, 16'h0004, 16'h0010};
        chain[7] = '{3'b111, 16'h0004, 16'h0001};
        chain[8] = '{3'b101, 16'hFFFF, 16'h0000};

        bnd[0] = '{3'b000, 16'h0001, 16'h8000};
        bnd[1] = '{3'b111, 16'h001F, 16'hFFFF};
        bnd[2] = '{3'b010, 16'h0001, 16'h0001};
        bnd[3] = '{3'b110, 16'h0010, 16'h0000};

        #1;
        tick();
        tick();
        check("reset", led, 16'h0000);
        btnu = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("idle", led, 16'h0000);

        for (int i = 0; i < 9; i++) press(chain[i].op, chain[i].sw, chain[i].exp, $sformatf("chain%0d", i));

        // Holding btnd must update exactly once; op/sw changes while held are ignored.
        op_sel = 3'b000;
        sw     = 16'h0001;
        btnd   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold%0d", i), led, 16'h0001);
        end
        op_sel = 3'b011;
        sw     = 16'hABCD;
        tick();
        tick();
        check("steady_change", led, 16'h0001);
        btnd = 1'b0;
        tick();
        op_sel = 3'b100;
        sw     = 16'h5555;
        tick();
        check("idle_change", led, 16'h0001);

        // Reset on the press edge wins; btnd held through release then counts as a press.
        btnd = 1'b1;
        btnu = 1'b0;
        tick();
        check("reset_on_press", led, 16'h0000);
        op_sel = 3'b011;
        sw     = 16'h7FFF;
        btnu   = 1'b1;
        tick();
        check("press_after_reset", led, 16'h7FFF);
        btnd = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) press(bnd[i].op, bnd[i].sw, bnd[i].exp, $sformatf("bound%0d", i));

        // Random phase against the reference model.
        btnu = 1'b0;
        btnd = 1'b0;
        tick();
        btnu   = 1'b1;
        m_acc  = 16'h0000;
        m_prev = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            btnu   = ($urandom_range(0, 63) != 0);
            btnd   = ($urandom_range(0, 2) == 0) ? ~btnd : btnd;
            op_sel = 3'($urandom_range(0, 7));
            sw     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            if (!btnu) begin
                m_acc  = 16'h0000;
                m_prev = 1'b0;
            end else begin
                if (btnd && !m_prev) m_acc = ref_alu(m_acc, op_sel, sw);
                m_prev = btnd;
            end
            tick();
            check($sformatf("rand%0d", i), led, m_acc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
